calc_key_sequencer: RTL

Sequencing controller that sits between the keypad controller and the calculator arithmetic unit. It drives the keypad controller's `enable`/`ack` handshake, consumes one 4-bit key code per key press, and assembles two BCD operands and an operator into one operation request. It presents that request to the arithmetic unit with a valid/ready handshake. It also provides the operand currently being entered to the display path and flags entry errors.

---
 rtl/calc_key_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer
//
// Sequencing controller between the keypad controller and the calculator
// arithmetic unit. It runs the four-phase enable/ack handshake with the
// keypad, assembles two BCD operands and an operator from key codes, and
// issues one operation request per '=' over a valid/ready handshake.
//
// Parameters:
//   DIGITS      maximum BCD digits per operand (>= 1)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   key_done    keypad controller done: key_code is valid
//   key_code    0-9 digit, 10 '+', 11 '-', 12 '*', 13 '/', 14 clear, 15 '='
//   key_enable  keypad controller enable (registered)
//   key_ack     keypad controller ack (registered)
//   op_a/op_b   BCD operands, most significant digit first
//   opcode      00 add, 01 sub, 10 mul, 11 div
//   op_valid    operation request valid
//   op_ready    arithmetic unit accepts the request
//   disp_data   operand currently being entered
//   error       sticky entry error, cleared only by clear key or reset
module calc_key_sequencer #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_done,
    input  logic [3:0]            key_code,
    output logic                  key_enable,
    output logic                  key_ack,
    output logic [4*DIGITS-1:0]   op_a,
    output logic [4*DIGITS-1:0]   op_b,
    output logic [1:0]            opcode,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [4*DIGITS-1:0]   disp_data,
    output logic                  error
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        StA,
        StB,
        StIssue
    } state_e;

    state_e          state_q, state_d;
    logic            ack_q, ack_d;
    logic            en_q, en_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic [1:0]      opcode_q, opcode_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_a_q, cnt_a_d;
    logic [CW-1:0]   cnt_b_q, cnt_b_d;

    // Key decode and working copies of the operand being entered.
    logic            fire;
    logic            is_digit;
    logic            is_oper;
    logic            is_clear;
    logic            is_equal;
    logic [W-1:0]    act_op;
    logic [CW-1:0]   act_cnt;
    logic [W-1:0]    shifted;

    assign fire     = key_done && en_q;
    assign is_digit = (key_code <= 4'd9);
    assign is_oper  = (key_code >= 4'd10) && (key_code <= 4'd13);
    assign is_clear = (key_code == 4'd14);
    assign is_equal = (key_code == 4'd15);
    assign act_op   = (state_q == StA) ? op_a_q : op_b_q;
    assign act_cnt  = (state_q == StA) ? cnt_a_q : cnt_b_q;

    always_comb begin
        shifted      = act_op << 4;
        shifted[3:0] = key_code;
    end

    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        opcode_d = opcode_q;
        valid_d  = valid_q;
        err_d    = err_q;
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;

        // Ack rises with the accepted key and falls once done is seen low,
        // regardless of state, so a handshake started by '=' still completes.
        if (fire) begin
            ack_d = 1'b1;
        end else if (ack_q && !key_done) begin
            ack_d = 1'b0;
        end

        // en_q is only ever set in StA/StB, so fire implies an entry state.
        if (fire) begin
            if (is_digit) begin
                if ((act_op == '0) && (key_code == 4'd0)) begin
                    // Leading zero: nothing to record.
                end else if (act_cnt < CW'(DIGITS)) begin
                    if (state_q == StA) begin
                        op_a_d  = shifted;
                        cnt_a_d = cnt_a_q + CW'(1);
                    end else begin
                        op_b_d  = shifted;
                        cnt_b_d = cnt_b_q + CW'(1);
                    end
                end else begin
                    err_d = 1'b1;
                end
            end else if (is_oper) begin
                if (state_q == StA) begin
                    // code-10 mod 4 equals code[1:0]+2 mod 4.
                    opcode_d = key_code[1:0] + 2'd2;
                    cnt_b_d  = '0;
                    state_d  = StB;
                end else if (cnt_b_q == '0) begin
                    opcode_d = key_code[1:0] + 2'd2;
                end else begin
                    err_d = 1'b1;
                end
            end else if (is_clear) begin
                op_a_d   = '0;
                op_b_d   = '0;
                opcode_d = 2'b00;
                cnt_a_d  = '0;
                cnt_b_d  = '0;
                err_d    = 1'b0;
                state_d  = StA;
            end else if (is_equal) begin
                if (state_q == StB) begin
                    valid_d = 1'b1;
                    state_d = StIssue;
                end
            end
        end

        if ((state_q == StIssue) && op_ready) begin
            valid_d = 1'b0;
            op_a_d  = '0;
            op_b_d  = '0;
            cnt_a_d = '0;
            cnt_b_d = '0;
            state_d = StA;
        end

        en_d = (state_d != StIssue) && !ack_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StA;
            ack_q    <= 1'b0;
            en_q     <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            opcode_q <= 2'b00;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            en_q     <= en_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            opcode_q <= opcode_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
        end
    end

    assign key_enable = en_q;
    assign key_ack    = ack_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign opcode     = opcode_q;
    assign op_valid   = valid_q;
    assign error      = err_q;
    assign disp_data  = (state_q == StA) ? op_a_q : op_b_q;

endmodule
